// File: rtl/ras.sv
// Return address stack for the fetch predictor: circular push/pop with checkpoint restore.
// Optional define RAS_EMPTY_ZERO_EN forces ret_pc to 0 while the stack is empty.
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_pc,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
    input  logic [RAS_INDEX_WIDTH:0]    update_ras_count
);

    // Request semantics: link_valid, ret_valid and update_valid are single-cycle
    // strobes with no ready; every request is consumed on the edge that samples it.

    localparam logic [RAS_INDEX_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [RAS_INDEX_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [RAS_INDEX_WIDTH:0]   CNT_FULL = RAS_ENTRIES[RAS_INDEX_WIDTH:0];

    logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  top;
    logic [RAS_INDEX_WIDTH:0]    count;
    logic [RAS_INDEX_WIDTH-1:0]  top_inc;
    logic [RAS_INDEX_WIDTH-1:0]  top_dec;

    assign top_inc = top + IDX_ONE;
    assign top_dec = top - IDX_ONE;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack[i] <= '0;
            end
            top   <= '0;
            count <= '0;
        end else if (update_valid) begin
            top   <= update_ras_index;
            count <= update_ras_count;
        end else if (link_valid && ret_valid) begin
            // Coroutine jalr: replace the entry just consumed, depth unchanged.
            stack[top] <= link_pc;
        end else if (link_valid) begin
            top          <= top_inc;
            stack[top_inc] <= link_pc;
            count        <= (count == CNT_FULL) ? CNT_FULL : count + CNT_ONE;
        end else if (ret_valid) begin
            top   <= top_dec;
            count <= (count == '0) ? '0 : count - CNT_ONE;
        end
    end

`ifdef RAS_EMPTY_ZERO_EN
    assign ret_pc = (count == '0) ? '0 : stack[top];
`else
    assign ret_pc = stack[top];
`endif

    assign ras_index = top;
    assign ras_count = count;

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: random and directed requests against a behavioural stack model,
// with expected outputs queued by the driver and compared by a monitor on the falling edge.
module tb_ras;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 31;
    localparam int EW = TW + IW + IW + 1;

`ifdef RAS_EMPTY_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    // clock / reset
    logic          CLK = 1'b0;
    logic          nRST;
    logic          link_valid;
    logic [TW-1:0] link_pc;
    logic          ret_valid;
    logic [TW-1:0] ret_pc;
    logic [IW-1:0] ras_index;
    logic [IW:0]   ras_count;
    logic          update_valid;
    logic [IW-1:0] update_ras_index;
    logic [IW:0]   update_ras_count;

    always #5 CLK = ~CLK;

    ras dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .link_valid       (link_valid),
        .link_pc          (link_pc),
        .ret_valid        (ret_valid),
        .ret_pc           (ret_pc),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index),
        .update_ras_count (update_ras_count)
    );

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: a plain array with a top-of-stack slot and a depth counter.
    int unsigned m_stack[N];
    int          m_top;
    int          m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_stack[i] = 0;
        m_top   = 0;
        m_count = 0;
    endtask

    function automatic logic [EW-1:0] model_outputs();
        int unsigned r;
        r = (ZERO_EN && m_count == 0) ? 0 : m_stack[m_top];
        return {r[TW-1:0], m_top[IW-1:0], m_count[IW:0]};
    endfunction

    task automatic model_update(input bit lv, input int unsigned lpc, input bit rv,
                                input bit uv, input int ui, input int uc);
        if (uv) begin
            m_top   = ui;
            m_count = uc;
        end else if (lv && rv) begin
            m_stack[m_top] = lpc;
        end else if (lv) begin
            m_top          = (m_top + 1) % N;
            m_stack[m_top] = lpc;
            m_count        = (m_count < N) ? m_count + 1 : N;
        end else if (rv) begin
            m_top   = (m_top + N - 1) % N;
            m_count = (m_count > 0) ? m_count - 1 : 0;
        end
    endtask

    // driver: one call per clock cycle
    task automatic step(input bit lv, input int unsigned lpc, input bit rv,
                        input bit uv, input int ui, input int uc);
        @(posedge CLK);
        #1;
        link_valid       = lv;
        link_pc          = lpc[TW-1:0];
        ret_valid        = rv;
        update_valid     = uv;
        update_ras_index = ui[IW-1:0];
        update_ras_count = uc[IW:0];
        exp_q.push_back(model_outputs());
        model_update(lv, lpc, rv, uv, ui, uc);
    endtask

    task automatic push(input int unsigned pc); step(1, pc, 0, 0, 0, 0); endtask
    task automatic pop();                       step(0, 0, 1, 0, 0, 0); endtask
    task automatic idle();                      step(0, 0, 0, 0, 0, 0); endtask

    // Asserts reset mid-cycle with a push pending and checks outputs clear without an edge.
    task automatic async_reset();
        @(posedge CLK);
        #1;
        link_valid = 1'b1;
        link_pc    = 31'h7777;
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst ret_pc", 64'(ret_pc), 64'd0);
        check("async_rst ras_index", 64'(ras_index), 64'd0);
        check("async_rst ras_count", 64'(ras_count), 64'd0);
        @(posedge CLK);
        #1;
        nRST         = 1'b1;
        link_valid   = 1'b0;
        ret_valid    = 1'b0;
        update_valid = 1'b0;
        model_reset();
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (nRST && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ret_pc", 64'(ret_pc), 64'(e[EW-1 -: TW]));
            check("ras_index", 64'(ras_index), 64'(e[IW+IW -: IW]));
            check("ras_count", 64'(ras_count), 64'(e[IW:0]));
        end
    end

    initial begin
        link_valid       = 1'b0;
        link_pc          = '0;
        ret_valid        = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
        update_ras_count = '0;
        nRST             = 1'b1;
        model_reset();
        #1 nRST = 1'b0;
        #2;
        check("reset ret_pc", 64'(ret_pc), 64'd0);
        check("reset ras_index", 64'(ras_index), 64'd0);
        check("reset ras_count", 64'(ras_count), 64'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // two pushes then two pops
        push(32'h100); push(32'h200); pop(); pop(); idle();

        // overflow by one, then unwind past empty
        async_reset();
        for (int i = 1; i <= 9; i++) push(i);
        for (int i = 0; i < 9; i++) pop();
        idle();

        // push+pop on a three-deep stack
        async_reset();
        push(32'h100); push(32'h200); push(32'h300);
        step(1, 32'h444, 1, 0, 0, 0);
        idle();

        // checkpoint restore wins over a concurrent push
        async_reset();
        push(32'h100); push(32'h200); push(32'h300);
        push(32'h500); push(32'h600);
        step(1, 32'h999, 0, 1, 3, 3);
        idle();

        // pop from reset state wraps the pointer
        async_reset();
        pop(); idle();

        // reset with five entries held and a push in flight
        async_reset();
        for (int i = 0; i < 5; i++) push(32'h1000 + i);
        idle();
        async_reset();
        idle(); pop(); idle();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit          uv;
            bit          lv;
            bit          rv;
            int unsigned pc;
            uv = ($urandom_range(0, 15) == 0);
            lv = $urandom_range(0, 1);
            rv = $urandom_range(0, 1);
            pc = $urandom() & 32'h7fff_ffff;
            step(lv, pc, rv, uv, $urandom_range(0, N - 1), $urandom_range(0, N));
        end
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
